// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared opcodes, result classes, bus widths and divider states
//               for the MIPS32 execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int REG_BUS_W = 32;

    localparam logic [4:0] NOP_REG_ADDR  = 5'b00000;
    localparam logic       STALL_ENABLE  = 1'b1;
    localparam logic       STALL_DISABLE = 1'b0;

    localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Sequential radix-2 restoring divider (signed or unsigned).
//               result = {remainder, quotient}; ready marks the END cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_e       state_q, state_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      w_trial;

    // Quotient register doubles as the dividend shift-in source.
    assign w_trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        case (state_q)
            DIV_FREE: begin
                if (start) begin
                    neg_quo_d = signed_div & (opdata1[31] ^ opdata2[31]);
                    neg_rem_d = signed_div & opdata1[31];
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (opdata2 == '0) begin
                        state_d = DIV_BY_ZERO;
                        quo_d   = '0;
                        dvsr_d  = '0;
                    end else begin
                        state_d = DIV_ON;
                        quo_d   = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
                        dvsr_d  = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d = DIV_END;
                quo_d   = '0;
                rem_d   = '0;
            end
            DIV_ON: begin
                if (!w_trial[32]) begin
                    rem_d = w_trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: state_d = DIV_FREE;
            default: state_d = DIV_FREE;
        endcase
        if (annul) begin
            state_d = DIV_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ready  = (state_q == DIV_END);
    assign result = {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : MIPS32 execute stage: combinational ALU plus stalling divider.
//               Optional macro EX_OVF_TRAP_EN enables ADD/SUB overflow trap.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o,
    output logic        ovf_o
);

    logic        w_is_div;
    logic        w_div_ready;
    logic [63:0] w_div_result;
    logic        w_ovf;
    logic [31:0] w_logic, w_shift, w_arith, w_wdata;

    assign w_is_div = is_div_op(aluop_i);

    div_unit #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_is_div & ~flush_i),
        .signed_div(aluop_i == EXE_DIV_OP),
        .opdata1   (reg1_i),
        .opdata2   (reg2_i),
        .annul     (flush_i),
        .result    (w_div_result),
        .ready     (w_div_ready)
    );

    always_comb begin
        w_logic = '0;
        w_shift = '0;
        w_arith = '0;
        case (aluop_i)
            EXE_AND_OP:  w_logic = reg1_i & reg2_i;
            EXE_OR_OP:   w_logic = reg1_i | reg2_i;
            EXE_XOR_OP:  w_logic = reg1_i ^ reg2_i;
            EXE_NOR_OP:  w_logic = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  w_shift = reg2_i << reg1_i[4:0];
            EXE_SRL_OP:  w_shift = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP:  w_shift = $signed(reg2_i) >>> reg1_i[4:0];
            EXE_ADD_OP, EXE_ADDU_OP: w_arith = reg1_i + reg2_i;
            EXE_SUB_OP, EXE_SUBU_OP: w_arith = reg1_i - reg2_i;
            EXE_SLT_OP:  w_arith = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: w_arith = {31'b0, reg1_i < reg2_i};
            default: ;
        endcase
    end

    always_comb begin
        case (alusel_i)
            EXE_RES_LOGIC: w_wdata = w_logic;
            EXE_RES_SHIFT: w_wdata = w_shift;
            EXE_RES_ARITH: w_wdata = w_arith;
            default:       w_wdata = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    logic [31:0] w_opb;
    logic        w_trap_op;

    assign w_trap_op = (alusel_i == EXE_RES_ARITH) &&
                       ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_SUB_OP));
    assign w_opb     = (aluop_i == EXE_SUB_OP) ? -reg2_i : reg2_i;
    assign w_ovf     = w_trap_op && (reg1_i[31] == w_opb[31]) &&
                       (w_arith[31] != reg1_i[31]);
`else
    assign w_ovf = 1'b0;
`endif

    // Reset forces every output low regardless of the incoming operation.
    assign wd_o       = rst ? NOP_REG_ADDR : wd_i;
    assign wreg_o     = ~rst & wreg_i & ~w_is_div & ~w_ovf;
    assign wdata_o    = rst ? '0 : w_wdata;
    assign ovf_o      = ~rst & w_ovf;
    assign whilo_o    = ~rst & w_div_ready & ~flush_i;
    assign stallreq_o = (~rst & w_is_div & ~w_div_ready & ~flush_i) ? STALL_ENABLE
                                                                      : STALL_DISABLE;
    assign hi_o       = whilo_o ? w_div_result[63:32] : '0;
    assign lo_o       = whilo_o ? w_div_result[31:0]  : '0;

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. Sits between the id_ex pipeline register and the ex_mem pipeline register.
- Consumes the decoded operation, operands and destination produced by decode.
- Produces the GPR write-back triple, which also feeds decode forwarding via ex_wreg/ex_wd/ex_wdata, and the HI/LO write request.
- Contains a sequential radix-2 divider FSM that stalls the pipeline for DIV/DIVU.

Parameters:
- DIV_CYCLES, 32, number of divide iterations; must equal the RegBus width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- flush_i  in  1  cancel the in-flight instruction; divider returns to IDLE
- aluop_i  in  8  operation code (AluOpBus)
- alusel_i  in  3  result class (AluSelBus)
- reg1_i  in  32  operand 1
- reg2_i  in  32  operand 2
- wd_i  in  5  destination GPR
- wreg_i  in  1  GPR write enable
- wd_o  out  5  destination GPR to ex_mem and decode forwarding
- wreg_o  out  1  GPR write enable
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write data (remainder)
- lo_o  out  32  LO write data (quotient)
- stallreq_o  out  1  stall request to pipeline control
- ovf_o  out  1  overflow exception flag (optional feature only)

Behaviour:
- Reset: rst is synchronous, active-high. While rst=1, every output is 0 combinationally (wd_o=NOPRegAddr). At the clock edge the divider state becomes IDLE and all divider registers clear.
- Single-cycle ops are combinational from inputs to outputs, zero latency. wd_o=wd_i, wreg_o=wreg_i.
- Logic (alusel LOGIC): AND, OR, XOR, NOR.
- Shift (alusel SHIFT): SLL, SRL, SRA. Shift amount is reg1_i[4:0]; value is reg2_i.
- Arith (alusel ARITH):
  - ADDU and SUBU wrap mod 2^32.
  - SLT compares signed; SLTU compares unsigned. Result is 32'd1 or 32'd0.
- Unknown aluop or alusel NOP: wdata_o=0, wreg_o still passes wreg_i.
- DIV/DIVU: wreg_o=0, whilo_o=1 only in the END cycle. Divider states are:
  - IDLE:
    - Div op present and flush_i=0, reg2_i==0: stallreq=1; next state BY_ZERO.
    - Div op present and flush_i=0, reg2_i nonzero: stallreq=1; next state ON.
    - On entry to ON: latch magnitudes (DIV negates negative operands), record signs, count=0.
  - BY_ZERO: stallreq=1; next state END with quotient=0, remainder=0.
  - ON: one restoring shift-subtract step per cycle; stallreq=1. After DIV_CYCLES steps, next state END.
  - END:
    - stallreq=0; whilo_o=1.
    - lo_o=quotient, negated if DIV and operand signs differ.
    - hi_o=remainder, negated if DIV and dividend negative.
    - Next state IDLE unconditionally.
- Latency: DIV/DIVU with nonzero divisor occupies EX for 34 cycles (issue + 32 ON + END). Divide by zero occupies 3 cycles.
- Upstream holds aluop_i/reg1_i/reg2_i constant while stallreq_o=1. Operands are latched at issue; changes during ON are ignored.
- flush_i=1 in any state: next state IDLE, stallreq_o=0 that cycle, whilo_o=0.
- rst has priority over flush_i.
- Non-div op while state≠IDLE cannot occur; it has no effect on the FSM.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined: adds ADD and SUB.
  - Signed overflow occurs when the operand signs match and the result sign differs, after negating reg2 for SUB.
  - On overflow: ovf_o=1 and wreg_o=0.
  - Without overflow: ovf_o=0 and the op behaves as ADDU/SUBU.
- Undefined: ADD/SUB decode as ADDU/SUBU; ovf_o is tied to 0.

Decomposition:
- Shared define.v:
  - All EXE_*_OP and EXE_RES_* codes; new codes EXE_DIV_OP 8'b00011010 and EXE_DIVU_OP 8'b00011011.
  - Divider state encodings DivFree/DivByZero/DivOn/DivEnd.
  - Bus width macros; StallEnable/StallDisable.
- One sub-module, div_unit: the FSM plus shift-subtract datapath. Interface is start, signed_div, opdata1, opdata2, annul, result[63:0], ready.
- ex_stage keeps the combinational ALU, result muxing and stall generation.

Test Plan:
- OR: reg1=32'h0000_1100, reg2=32'h0000_0011, wd_i=5, wreg_i=1 -> same cycle wdata_o=32'h0000_1111, wd_o=5, wreg_o=1, stallreq_o=0.
- SLT/SLTU: reg1=32'hFFFF_FFFF, reg2=1 -> SLT gives wdata_o=1; SLTU gives wdata_o=0.
- DIV: 7 by 32'hFFFF_FFFE (-2) -> stallreq_o=1 for 33 cycles; END cycle has lo_o=32'hFFFF_FFFD, hi_o=1, whilo_o=1, wreg_o=0.
- DIVU by zero: reg1=9, reg2=0 -> stall 2 cycles, then END with hi_o=lo_o=0 and whilo_o=1.
- Flush and reset mid-divide:
  - flush_i at ON cycle 10 -> stallreq_o=0 the same cycle, FSM in IDLE next cycle. Following DIVU 100/7 gives lo=14, hi=2.
  - rst at ON cycle 5 -> outputs 0, IDLE after the edge.
- EX_OVF_TRAP_EN: ADD 32'h7FFF_FFFF+1 -> ovf_o=1, wreg_o=0. Without the macro: wdata_o=32'h8000_0000, wreg_o=1.
